prbs_lfsr_checker: RTL and testbench

- Receive-side counterpart to the team's LFSR noise/pattern generator.
- Accepts the parallel N-bit words that the generator emits (one per data_valid) and self-synchronizes by seeding a local LFSR from the received stream.
- Once locked, predicts each subsequent word, flags mismatches and keeps saturating error/word counters.
- Used for loopback and link integrity checks on the display data path.

---
 rtl/prbs_lfsr_checker_pkg.sv | 25 ++
 rtl/prbs_lfsr_checker_lfsr_next_word.sv | 24 ++
 rtl/prbs_lfsr_checker.sv | 155 +++++++++++++++
 tb/tb_prbs_lfsr_checker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/prbs_lfsr_checker_pkg.sv
// Shared definitions for the LFSR pattern generator and its receive-side checker:
// FSM state encoding, generator reset seeds and the feedback taps of the sequence.
package prbs_lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Generator reset seeds, one per supported width.
    localparam logic [3:0] SEED_N4 = 4'h9;
    localparam logic [7:0] SEED_N8 = 8'hFF;

    // Feedback bit for the 4-bit sequence (period 15).
    function automatic logic lfsr_fb4(input logic [3:0] x);
        return x[0] ^ x[1];
    endfunction

    // Feedback bit for the 8-bit sequence.
    function automatic logic lfsr_fb8(input logic [7:0] x);
        return x[0] ^ x[4] ^ x[5] ^ x[6];
    endfunction

endpackage

// File: rtl/prbs_lfsr_checker_lfsr_next_word.sv
// Combinational next(x) = {fb, x[N-1:1]} for the supported LFSR widths.
// Unsupported widths get a feedback bit of 0.
module lfsr_next_word
    import prbs_lfsr_checker_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] x_i,
    output logic [N-1:0] next_o
);

    logic fb;

    if (N == 4) begin : g_n4
        assign fb = lfsr_fb4(x_i[3:0]);
    end else if (N == 8) begin : g_n8
        assign fb = lfsr_fb8(x_i[7:0]);
    end else begin : g_unsupported
        assign fb = 1'b0;
    end

    assign next_o = {fb, x_i[N-1:1]};

endmodule

// File: rtl/prbs_lfsr_checker.sv
// Receive-side PRBS checker: seeds a local LFSR from the incoming words, confirms
// LOCK_COUNT consecutive predictions, then free-runs and counts mispredicted words.
module prbs_lfsr_checker
    import prbs_lfsr_checker_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     data_in,
    input  logic             data_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic             error_pulse,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] word_count
);

    localparam bit          SUPPORTED = (N == 4) || (N == 8);
    localparam int unsigned MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W    = $clog2(LOSS_COUNT + 1);

    state_e             state_q, state_d;
    logic [N-1:0]       pred_q, pred_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               locked_q, locked_d;
    logic               error_pulse_q, error_pulse_d;
    logic [CNT_W-1:0]   error_count_q, error_count_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;

    logic [N-1:0]       next_data;
    logic [N-1:0]       next_pred;
    logic [MATCH_W-1:0] match_inc;
    logic [MISS_W-1:0]  miss_inc;
    logic               err_inc;
    logic               word_inc;

    // Reseed path: successor of the received word.
    lfsr_next_word #(.N(N)) u_next_data (
        .x_i    (data_in),
        .next_o (next_data)
    );

    // Flywheel path: successor of the current prediction.
    lfsr_next_word #(.N(N)) u_next_pred (
        .x_i    (pred_q),
        .next_o (next_pred)
    );

    assign match_inc = match_cnt_q + MATCH_W'(1);
    assign miss_inc  = miss_cnt_q + MISS_W'(1);

    // Next-state logic for the hunt/verify/locked FSM and its counters.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        pred_d        = pred_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        error_pulse_d = 1'b0;
        err_inc       = 1'b0;
        word_inc      = 1'b0;

        if (data_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    // All-zero is the lockup state and can never seed the LFSR.
                    if (SUPPORTED && data_in != '0) begin
                        pred_d      = next_data;
                        match_cnt_d = '0;
                        state_d     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (data_in == pred_q) begin
                        pred_d      = next_data;
                        match_cnt_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (data_in != '0) begin
                        pred_d      = next_data;
                        match_cnt_d = '0;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    // The flywheel never reseeds from data once locked.
                    word_inc = 1'b1;
                    pred_d   = next_pred;
                    if (data_in == pred_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        error_pulse_d = 1'b1;
                        err_inc       = 1'b1;
                        if (miss_inc == MISS_W'(LOSS_COUNT)) begin
                            state_d    = ST_HUNT;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);

        // clear_counts wins over a same-cycle increment; counters saturate at all-ones.
        if (clear_counts)                       error_count_d = '0;
        else if (err_inc && error_count_q != '1) error_count_d = error_count_q + CNT_W'(1);
        else                                    error_count_d = error_count_q;

        if (clear_counts)                       word_count_d = '0;
        else if (word_inc && word_count_q != '1) word_count_d = word_count_q + CNT_W'(1);
        else                                    word_count_d = word_count_q;
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q       <= ST_HUNT;
            pred_q        <= '0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            error_count_q <= '0;
            word_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            pred_q        <= pred_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            locked_q      <= locked_d;
            error_pulse_q <= error_pulse_d;
            error_count_q <= error_count_d;
            word_count_q  <= word_count_d;
        end
    end

    assign locked      = locked_q;
    assign error_pulse = error_pulse_q;
    assign error_count = error_count_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_prbs_lfsr_checker.sv
// Directed bench for prbs_lfsr_checker: N=4 with 16-bit and 4-bit counters, plus N=8.
module tb_prbs_lfsr_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       dv;
    logic       clr;

    logic        lk4, ep4;
    logic [15:0] ec4, wc4;
    logic        lks, eps;
    logic [3:0]  ecs, wcs;
    logic        lk8, ep8;
    logic [15:0] ec8, wc8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prbs_lfsr_checker #(.N(4), .LOCK_COUNT(3), .LOSS_COUNT(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .data_in(din[3:0]), .data_valid(dv), .clear_counts(clr),
        .locked(lk4), .error_pulse(ep4), .error_count(ec4), .word_count(wc4)
    );

    prbs_lfsr_checker #(.N(4), .LOCK_COUNT(3), .LOSS_COUNT(4), .CNT_W(4)) dut4s (
        .clk(clk), .reset(reset), .data_in(din[3:0]), .data_valid(dv), .clear_counts(clr),
        .locked(lks), .error_pulse(eps), .error_count(ecs), .word_count(wcs)
    );

    prbs_lfsr_checker #(.N(8), .LOCK_COUNT(3), .LOSS_COUNT(4), .CNT_W(16)) dut8 (
        .clk(clk), .reset(reset), .data_in(din), .data_valid(dv), .clear_counts(clr),
        .locked(lk8), .error_pulse(ep8), .error_count(ec8), .word_count(wc8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one word on the falling edge, then sample 1 ns after the rising edge.
    task automatic cycle(input logic [7:0] w, input logic v);
        @(negedge clk);
        din = w;
        dv  = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] nxt4(input logic [3:0] x);
        return {x[0] ^ x[1], x[3:1]};
    endfunction

    initial begin
        logic [3:0] p;
        reset = 1'b1;
        din   = '0;
        dv    = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", lk4, 0);
        check("rst_pulse", ep4, 0);
        check("rst_errcnt", ec4, 0);
        check("rst_wordcnt", wc4, 0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: acquire lock on 9,C,6,B.
        cycle(8'h9, 1); check("t1_after9", lk4, 0);
        cycle(8'hC, 1);
        cycle(8'h6, 1); check("t1_after6", lk4, 0);
        cycle(8'hB, 1); check("t1_lock", lk4, 1);
        check("t1_errcnt", ec4, 0);
        check("t1_wordcnt", wc4, 0);

        // Test 2: one corrupted word (0 instead of A).
        cycle(8'h5, 1); check("t2_pulse5", ep4, 0);
        cycle(8'h0, 1); check("t2_pulse0", ep4, 1);
        check("t2_err1", ec4, 1);
        cycle(8'hD, 1); check("t2_pulseD", ep4, 0);
        cycle(8'hE, 1); check("t2_pulseE", ep4, 0);
        check("t2_errcnt", ec4, 1);
        check("t2_wordcnt", wc4, 4);
        check("t2_locked", lk4, 1);
        cycle(8'h0, 0); check("t2_gap_pulse", ep4, 0);
        check("t2_gap_err", ec4, 1);

        // Test 3: four wrong words drop lock (pred F,7,3,1), then relock on 7,3,1,8.
        for (int i = 0; i < 4; i++) begin
            cycle(8'h0, 1);
            check("t3_pulse", ep4, 1);
            check("t3_locked", lk4, (i == 3) ? 0 : 1);
        end
        check("t3_errcnt", ec4, 5);
        check("t3_wordcnt", wc4, 8);
        cycle(8'h7, 1);
        cycle(8'h3, 1);
        cycle(8'h1, 1); check("t3_prelock", lk4, 0);
        cycle(8'h8, 1); check("t3_relock", lk4, 1);
        check("t3_relock_s", lks, 1);

        // Test 5: alternate bad/good words; flywheel prediction starts at 4.
        p = 4'h4;
        for (int i = 0; i < 20; i++) begin
            cycle(8'h0, 1);
            check("t5_bad_pulse", eps, 1);
            p = nxt4(p);
            cycle({4'h0, p}, 1);
            check("t5_good_pulse", eps, 0);
            p = nxt4(p);
        end
        check("t5_sat_err", ecs, 15);
        check("t5_sat_word", wcs, 15);
        check("t5_locked", lks, 1);
        check("t5_wide_err", ec4, 25);
        check("t5_wide_word", wc4, 48);
        clr = 1'b1;
        cycle(8'h0, 1);
        clr = 1'b0;
        check("t5_clr_pulse", eps, 1);
        check("t5_clr_err", ecs, 0);
        check("t5_clr_word", wcs, 0);
        check("t5_clr_err_w", ec4, 0);

        // Reset back to HUNT.
        @(negedge clk);
        dv    = 1'b0;
        reset = 1'b1;
        #1;
        check("rst2_locked", lk4, 0);
        @(negedge clk);
        reset = 1'b0;

        // Test 4: zeros ignored in HUNT, idle gaps do not advance.
        cycle(8'h0, 1);
        cycle(8'h0, 1); check("t4_zero_hunt", lk4, 0);
        cycle(8'h9, 1);
        cycle(8'h5, 0);
        cycle(8'hC, 1);
        cycle(8'h2, 0);
        cycle(8'h6, 1); check("t4_pre_gap", lk4, 0);
        cycle(8'hF, 0); check("t4_gap_pulse", ep4, 0);
        cycle(8'hB, 1); check("t4_lock", lk4, 1);
        check("t4_errcnt", ec4, 0);

        // Test 6: N=8 lock on FF,7F,3F,9F, one error, then asynchronous reset mid-cycle.
        @(negedge clk);
        dv    = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cycle(8'hFF, 1);
        cycle(8'h7F, 1);
        cycle(8'h3F, 1); check("t6_prelock", lk8, 0);
        cycle(8'h9F, 1); check("t6_lock", lk8, 1);
        cycle(8'h00, 1); check("t6_pulse", ep8, 1);
        check("t6_err", ec8, 1);
        check("t6_word", wc8, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_locked", lk8, 0);
        check("t6_async_err", ec8, 0);
        check("t6_async_word", wc8, 0);
        check("t6_async_pulse", ep8, 0);
        @(negedge clk);
        dv    = 1'b0;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
